// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: region decode, wait-state table, boot overlay, DTACK/BERR.
// Optional bus-error watchdog enabled by defining BUS_TIMEOUT_EN.
module m68k_bus_ctrl #(
  parameter int DEC_BITS    = 4,
  parameter int WS_BITS     = 4,
  parameter int DEFAULT_WS  = 2,
  parameter int BOOT_REGION = 8,
  parameter int BOOT_CYCLES = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                     sysclk,
  input  logic                     sysrst,
  input  logic                     as_n,
  input  logic [DEC_BITS-1:0]      addr_h,
  input  logic                     ws_we,
  input  logic [DEC_BITS-1:0]      ws_sel,
  input  logic [WS_BITS-1:0]       ws_wdata,
  input  logic [(2**DEC_BITS)-1:0] ext_sel,
  input  logic                     ext_dtack_n,
  output logic [(2**DEC_BITS)-1:0] cs_n,
  output logic                     dtack_n,
  output logic                     berr_n,
  output logic                     boot
);

  localparam int NREGION = 2**DEC_BITS;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ACK, S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [DEC_BITS-1:0]  region_q, region_d;
  logic [WS_BITS-1:0]   wcnt_q, wcnt_d;
  logic [NREGION-1:0]   cs_n_q, cs_n_d;
  logic                 dtack_n_q, dtack_n_d;
  logic                 berr_n_q, berr_n_d;
  logic                 boot_q, boot_d;
  logic [7:0]           bcnt_q, bcnt_d;
  logic [WS_BITS-1:0]   table_q [NREGION];
  logic [WS_BITS-1:0]   table_d [NREGION];
  logic                 as_meta_q, as_s_q;
  logic                 ack;

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]        tcnt_q, tcnt_d;
`endif

  // as_n is asynchronous to sysclk; deliberately left out of reset so a
  // held strobe restarts a cycle right after sysrst drops.
  always_ff @(posedge sysclk) begin
    as_meta_q <= as_n;
    as_s_q    <= as_meta_q;
  end

  assign ack = ext_sel[region_q] ? !ext_dtack_n : (wcnt_q == '0);

  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    wcnt_d    = wcnt_q;
    cs_n_d    = cs_n_q;
    dtack_n_d = dtack_n_q;
    berr_n_d  = berr_n_q;
    boot_d    = boot_q;
    bcnt_d    = bcnt_q;
    table_d   = table_q;
`ifdef BUS_TIMEOUT_EN
    tcnt_d    = tcnt_q;
`endif
    if (ws_we)
      table_d[ws_sel] = ws_wdata;
    unique case (state_q)
      S_IDLE: begin
        if (!as_s_q) begin
          region_d = (boot_q && addr_h == '0) ?
                     DEC_BITS'(BOOT_REGION) : addr_h;
          state_d  = S_WAIT;
          cs_n_d   = ~(NREGION'(1) << region_d);
          wcnt_d   = table_q[region_d];
`ifdef BUS_TIMEOUT_EN
          tcnt_d   = '0;
`endif
        end
      end
      default: begin
        if (as_s_q) begin
          state_d   = S_IDLE;
          cs_n_d    = '1;
          dtack_n_d = 1'b1;
          berr_n_d  = 1'b1;
          bcnt_d    = bcnt_q + 8'd1;
          if (bcnt_d == 8'(BOOT_CYCLES))
            boot_d = 1'b0;
        end else if (state_q == S_WAIT) begin
          if (ack) begin
            state_d   = S_ACK;
            dtack_n_d = 1'b0;
          end else begin
            if (wcnt_q != '0)
              wcnt_d = wcnt_q - 1'b1;
`ifdef BUS_TIMEOUT_EN
            tcnt_d = tcnt_q + 1'b1;
            if (tcnt_q == TW'(TIMEOUT - 1)) begin
              state_d  = S_ERR;
              berr_n_d = 1'b0;
            end
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (sysrst) begin
      state_q   <= S_IDLE;
      region_q  <= '0;
      wcnt_q    <= '0;
      cs_n_q    <= '1;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      boot_q    <= 1'b1;
      bcnt_q    <= '0;
      for (int i = 0; i < NREGION; i++)
        table_q[i] <= WS_BITS'(DEFAULT_WS);
`ifdef BUS_TIMEOUT_EN
      tcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      wcnt_q    <= wcnt_d;
      cs_n_q    <= cs_n_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
      boot_q    <= boot_d;
      bcnt_q    <= bcnt_d;
      table_q   <= table_d;
`ifdef BUS_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
`endif
    end
  end

  assign cs_n    = cs_n_q;
  assign dtack_n = dtack_n_q;
  assign berr_n  = berr_n_q;
  assign boot    = boot_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench for m68k_bus_ctrl: reset, boot overlay, wait states,
// external DTACK, abort, write/load collision, reset in ACK.
module tb_m68k_bus_ctrl;

  logic        sysclk = 1'b0;
  logic        sysrst;
  logic        as_n;
  logic [3:0]  addr_h;
  logic        ws_we;
  logic [3:0]  ws_sel;
  logic [3:0]  ws_wdata;
  logic [15:0] ext_sel;
  logic        ext_dtack_n;
  logic [15:0] cs_n;
  logic        dtack_n;
  logic        berr_n;
  logic        boot;

  int n_chk = 0;
  int n_fail = 0;

  m68k_bus_ctrl dut (
    .sysclk(sysclk), .sysrst(sysrst), .as_n(as_n), .addr_h(addr_h),
    .ws_we(ws_we), .ws_sel(ws_sel), .ws_wdata(ws_wdata),
    .ext_sel(ext_sel), .ext_dtack_n(ext_dtack_n),
    .cs_n(cs_n), .dtack_n(dtack_n), .berr_n(berr_n), .boot(boot)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_ws(input logic [3:0] sel, input logic [3:0] val);
    ws_we = 1'b1; ws_sel = sel; ws_wdata = val;
    tick(1);
    ws_we = 1'b0;
  endtask

  task automatic release_as(input string tag);
    as_n = 1'b1;
    tick(3);
    chk({tag, "_idle_cs"}, cs_n, 16'hFFFF);
    chk({tag, "_idle_dtack"}, {15'd0, dtack_n}, 16'd1);
  endtask

  initial begin
    sysrst = 1'b1; as_n = 1'b1; addr_h = '0;
    ws_we = 1'b0; ws_sel = '0; ws_wdata = '0;
    ext_sel = '0; ext_dtack_n = 1'b1;
    tick(3);
    sysrst = 1'b0;
    chk("rst_cs", cs_n, 16'hFFFF);
    chk("rst_dtack", {15'd0, dtack_n}, 16'd1);
    chk("rst_berr", {15'd0, berr_n}, 16'd1);
    chk("rst_boot", {15'd0, boot}, 16'd1);

    // four boot cycles remapped to region 8, default 2 wait states
    for (int i = 0; i < 4; i++) begin
      addr_h = 4'd0; as_n = 1'b0;
      tick(3);
      chk("boot_cs", cs_n, 16'hFEFF);
      chk("boot_boot", {15'd0, boot}, 16'd1);
      tick(2);
      chk("boot_dtack_hi", {15'd0, dtack_n}, 16'd1);
      tick(1);
      chk("boot_dtack_lo", {15'd0, dtack_n}, 16'd0);
      release_as("boot");
    end
    chk("boot_cleared", {15'd0, boot}, 16'd0);
    addr_h = 4'd0; as_n = 1'b0;
    tick(3);
    chk("post_boot_cs", cs_n, 16'hFFFE);
    release_as("post_boot");

    // zero wait states on region 3
    wr_ws(4'd3, 4'd0);
    addr_h = 4'd3; as_n = 1'b0;
    tick(3);
    chk("ws0_cs", cs_n, 16'hFFF7);
    chk("ws0_dtack_e2", {15'd0, dtack_n}, 16'd1);
    tick(1);
    chk("ws0_dtack_e3", {15'd0, dtack_n}, 16'd0);
    release_as("ws0");

    // five wait states: dtack at edge 8
    wr_ws(4'd3, 4'd5);
    as_n = 1'b0;
    tick(3);
    chk("ws5_cs", cs_n, 16'hFFF7);
    tick(5);
    chk("ws5_dtack_e7", {15'd0, dtack_n}, 16'd1);
    tick(1);
    chk("ws5_dtack_e8", {15'd0, dtack_n}, 16'd0);
    release_as("ws5");

    // external DTACK on region 15
    ext_sel = 16'h8000;
    addr_h = 4'd15; as_n = 1'b0;
    tick(3);
    chk("ext_cs", cs_n, 16'h7FFF);
    tick(6);
    chk("ext_wait", {15'd0, dtack_n}, 16'd1);
    ext_dtack_n = 1'b0;
    tick(1);
    chk("ext_dtack", {15'd0, dtack_n}, 16'd0);
    ext_dtack_n = 1'b1;
    release_as("ext");

    // abort with wcnt=2: no dtack pulse
    addr_h = 4'd4; as_n = 1'b0;
    tick(3);
    chk("abort_cs", cs_n, 16'hFFEF);
    as_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("abort_no_dtack", {15'd0, dtack_n}, 16'd1);
    end
    chk("abort_idle_cs", cs_n, 16'hFFFF);

    // table write on the same edge region 3 loads (table holds 5)
    addr_h = 4'd3; as_n = 1'b0;
    tick(2);
    ws_we = 1'b1; ws_sel = 4'd3; ws_wdata = 4'd0;
    tick(1);
    ws_we = 1'b0;
    chk("coll_cs", cs_n, 16'hFFF7);
    tick(5);
    chk("coll_old_e7", {15'd0, dtack_n}, 16'd1);
    tick(1);
    chk("coll_old_e8", {15'd0, dtack_n}, 16'd0);
    release_as("coll");
    as_n = 1'b0;
    tick(4);
    chk("coll_new_e3", {15'd0, dtack_n}, 16'd0);
    release_as("coll_new");

`ifdef BUS_TIMEOUT_EN
    addr_h = 4'd15; as_n = 1'b0; ext_dtack_n = 1'b1;
    tick(3);
    tick(254);
    chk("to_berr_hi", {15'd0, berr_n}, 16'd1);
    tick(1);
    chk("to_berr_lo", {15'd0, berr_n}, 16'd0);
    chk("to_dtack", {15'd0, dtack_n}, 16'd1);
    as_n = 1'b1;
    tick(3);
    chk("to_berr_rel", {15'd0, berr_n}, 16'd1);
`endif

    // reset while in ACK; held strobe restarts a cycle
    addr_h = 4'd5; as_n = 1'b0;
    tick(6);
    chk("rack_dtack", {15'd0, dtack_n}, 16'd0);
    sysrst = 1'b1;
    tick(1);
    sysrst = 1'b0;
    chk("rack_cs", cs_n, 16'hFFFF);
    chk("rack_dtack_rst", {15'd0, dtack_n}, 16'd1);
    chk("rack_boot", {15'd0, boot}, 16'd1);
    tick(1);
    chk("rack_restart_cs", cs_n, 16'hFFDF);
    release_as("rack");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
